cordic_iter_ctrl: RTL and testbench

//  Iterative sequencer for the single-stage cordic datapath: accepts one (x,y,z,mode) job
//  via valid/ready, drives the shared cordic stage once per iteration (stage index 0..n-1),

---
 rtl/cordic_iter_ctrl_if.sv | 26 ++
 rtl/cordic_iter_ctrl.sv | 133 +++++++++++++
 tb/tb_cordic_iter_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_iter_ctrl_if.sv
// rtl/cordic_iter_ctrl_if.sv - job request/result handshake between FPU front-end and cordic sequencer
interface cordic_iter_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_mode;
  logic [4:0]  in_iters;
  logic [31:0] in_x;
  logic [31:0] in_y;
  logic [31:0] in_z;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_x;
  logic [31:0] out_y;
  logic [31:0] out_z;
  logic        out_mode;

  modport master (
    output in_valid, in_mode, in_iters, in_x, in_y, in_z, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_z, out_mode
  );

  modport slave (
    input  in_valid, in_mode, in_iters, in_x, in_y, in_z, out_ready,
    output in_ready, out_valid, out_x, out_y, out_z, out_mode
  );
endinterface

// File: rtl/cordic_iter_ctrl.sv
// rtl/cordic_iter_ctrl.sv - iterative sequencer driving a shared single-stage cordic datapath
module cordic_iter_ctrl #(
  parameter int N_ITER    = 24,
  parameter int STAGE_LAT = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 abort_i,
  cordic_iter_ctrl_if.slave    job,
  output logic                 busy,
  output logic                 mode_err,
  output logic                 cdc_mode,
  output logic [4:0]           cdc_stage,
  output logic [31:0]          cdc_x,
  output logic [31:0]          cdc_y,
  output logic [31:0]          cdc_z,
  input  logic [31:0]          cdc_x_out,
  input  logic [31:0]          cdc_y_out,
  input  logic [31:0]          cdc_z_out,
  input  logic                 cdc_mode_out
);

  localparam int              LAT_W    = (STAGE_LAT > 1) ? $clog2(STAGE_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(STAGE_LAT - 1);
  localparam logic [4:0]       ITER_DEF = 5'(N_ITER);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [4:0]        iters_q, iters_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [31:0]       x_q, x_d, y_q, y_d, z_q, z_d;
  logic              mode_q, mode_d;
  logic              err_q, err_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      iters_q <= '0;
      lat_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      iters_q <= iters_d;
      lat_q   <= lat_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    iters_d = iters_q;
    lat_d   = lat_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    mode_d  = mode_q;
    err_d   = err_q;
    // Abort keeps the working registers so a discarded result stays observable.
    if (abort_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (job.in_valid) begin
            x_d     = job.in_x;
            y_d     = job.in_y;
            z_d     = job.in_z;
            mode_d  = job.in_mode;
            iters_d = (job.in_iters == 5'd0) ? ITER_DEF : job.in_iters;
            cnt_d   = '0;
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          lat_d   = LAT_LOAD;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (lat_q == '0) begin
            x_d   = cdc_x_out;
            y_d   = cdc_y_out;
            z_d   = cdc_z_out;
            err_d = err_q | (cdc_mode_out != mode_q);
            if (cnt_q == iters_q - 5'd1) begin
              state_d = S_DONE;
            end else begin
              cnt_d   = cnt_q + 5'd1;
              state_d = S_ISSUE;
            end
          end else begin
            lat_d = lat_q - LAT_W'(1);
          end
        end
        S_DONE: begin
          if (job.out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Stage inputs come straight from the working registers, which only move at capture,
  // so they stay constant across ISSUE and the whole WAIT window.
  assign cdc_x     = x_q;
  assign cdc_y     = y_q;
  assign cdc_z     = z_q;
  assign cdc_mode  = mode_q;
  assign cdc_stage = cnt_q;

  assign job.in_ready  = (state_q == S_IDLE) && !abort_i;
  assign job.out_valid = (state_q == S_DONE);
  assign job.out_x     = x_q;
  assign job.out_y     = y_q;
  assign job.out_z     = z_q;
  assign job.out_mode  = mode_q;
  assign busy          = (state_q != S_IDLE);
  assign mode_err      = err_q;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// tb/tb_cordic_iter_ctrl.sv - self-checking bench for cordic_iter_ctrl with stub cordic stage
module tb_cordic_iter_ctrl;
  localparam int L    = 1;
  localparam int NDEF = 24;
  localparam int P    = L + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        abort = 1'b0;
  logic        busy, mode_err, cdc_mode, cdc_mode_out;
  logic [4:0]  cdc_stage;
  logic [31:0] cdc_x, cdc_y, cdc_z, cdc_x_out, cdc_y_out, cdc_z_out;
  logic        flip_en = 1'b0;

  always #5 clk = ~clk;

  cordic_iter_ctrl_if job_if ();

  cordic_iter_ctrl #(.N_ITER(NDEF), .STAGE_LAT(L)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .abort_i      (abort),
    .job          (job_if.slave),
    .busy         (busy),
    .mode_err     (mode_err),
    .cdc_mode     (cdc_mode),
    .cdc_stage    (cdc_stage),
    .cdc_x        (cdc_x),
    .cdc_y        (cdc_y),
    .cdc_z        (cdc_z),
    .cdc_x_out    (cdc_x_out),
    .cdc_y_out    (cdc_y_out),
    .cdc_z_out    (cdc_z_out),
    .cdc_mode_out (cdc_mode_out)
  );

  // Stub stage, one cycle latency: x+1, y+stage, z-1, mode echoed (optionally flipped at stage 3)
  always @(posedge clk) begin
    cdc_x_out    <= cdc_x + 32'd1;
    cdc_y_out    <= cdc_y + {27'd0, cdc_stage};
    cdc_z_out    <= cdc_z - 32'd1;
    cdc_mode_out <= cdc_mode ^ (flip_en && cdc_stage == 5'd3);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a job is described by its acceptance edge and its parameters;
  // everything observable is derived from elapsed edges with plain arithmetic.
  int          n = 0;
  bit          m_act = 0;
  int          t_acc = 0;
  int          m_iters = 1;
  logic [31:0] m_x = 0, m_y = 0, m_z = 0;
  logic        m_mode = 0;
  bit          m_err = 0;
  bit          m_flip = 0;
  bit          m_stage0 = 1;
  int          e;

  always @(posedge clk) begin
    n++;
    if (!rst_n) begin
      m_act = 0; m_err = 0; m_stage0 = 1;
    end else if (abort) begin
      m_act = 0; m_stage0 = 1;
    end else if (!m_act) begin
      if (job_if.in_valid) begin
        m_act   = 1;
        t_acc   = n;
        m_iters = (job_if.in_iters == 5'd0) ? NDEF : int'(job_if.in_iters);
        m_x     = job_if.in_x;
        m_y     = job_if.in_y;
        m_z     = job_if.in_z;
        m_mode  = job_if.in_mode;
        m_flip  = flip_en;
      end
    end else begin
      e = n - t_acc;
      if (m_flip && m_iters > 3 && e == 4 * P) m_err = 1;
      if (e > m_iters * P && job_if.out_ready) begin
        m_act = 0; m_stage0 = 0;
      end
    end
  end

  int  ce, k;
  bit  dv;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("mode_err", {31'd0, mode_err}, {31'd0, m_err});
      if (m_act) begin
        ce = n - t_acc;
        dv = (ce >= m_iters * P);
        k  = dv ? m_iters - 1 : ce / P;
        chk("busy", {31'd0, busy}, 32'd1);
        chk("in_ready_busy", {31'd0, job_if.in_ready}, 32'd0);
        chk("out_valid", {31'd0, job_if.out_valid}, {31'd0, dv});
        chk("cdc_stage", {27'd0, cdc_stage}, 32'(k));
        chk("cdc_mode", {31'd0, cdc_mode}, {31'd0, m_mode});
        if (dv) begin
          chk("out_x", job_if.out_x, m_x + 32'(m_iters));
          chk("out_y", job_if.out_y, m_y + 32'(m_iters * (m_iters - 1) / 2));
          chk("out_z", job_if.out_z, m_z - 32'(m_iters));
          chk("out_mode", {31'd0, job_if.out_mode}, {31'd0, m_mode});
        end else begin
          chk("cdc_x", cdc_x, m_x + 32'(k));
          chk("cdc_y", cdc_y, m_y + 32'(k * (k - 1) / 2));
          chk("cdc_z", cdc_z, m_z - 32'(k));
        end
      end else begin
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("out_valid_idle", {31'd0, job_if.out_valid}, 32'd0);
        chk("in_ready_idle", {31'd0, job_if.in_ready}, {31'd0, ~abort});
        if (m_stage0) chk("cdc_stage_idle", {27'd0, cdc_stage}, 32'd0);
      end
    end
  end

  task automatic start_job(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                           input logic md, input logic [4:0] it);
    job_if.in_x     = x;
    job_if.in_y     = y;
    job_if.in_z     = z;
    job_if.in_mode  = md;
    job_if.in_iters = it;
    job_if.in_valid = 1'b1;
    @(posedge clk); #1;
    job_if.in_valid = 1'b0;
  endtask

  task automatic run_job(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                         input logic md, input logic [4:0] it, output int lat);
    start_job(x, y, z, md, it);
    lat = 0;
    while (!job_if.out_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  int lat, w;

  initial begin
    job_if.in_valid  = 1'b0;
    job_if.in_mode   = 1'b0;
    job_if.in_iters  = 5'd0;
    job_if.in_x      = '0;
    job_if.in_y      = '0;
    job_if.in_z      = '0;
    job_if.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, job_if.in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, job_if.out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mode_err", {31'd0, mode_err}, 32'd0);
    chk("rst_cdc_stage", {27'd0, cdc_stage}, 32'd0);
    chk("rst_out_x", job_if.out_x, 32'd0);
    @(posedge clk); #1;

    run_job(32'h3F800000, 32'd0, 32'h3F060A92, 1'b0, 5'd0, lat);
    chk("lat_default", 32'(lat), 32'd48);
    chk("lit_out_x", job_if.out_x, 32'h3F800018);
    chk("lit_out_y", job_if.out_y, 32'd276);
    chk("lit_out_z", job_if.out_z, 32'h3F060A7A);
    @(posedge clk); #1;
    chk("after_hs_busy", {31'd0, busy}, 32'd0);

    run_job(32'h12345678, 32'h9, 32'h40, 1'b1, 5'd1, lat);
    chk("lat_iters1", 32'(lat), 32'd2);
    @(posedge clk); #1;

    job_if.out_ready = 1'b0;
    run_job(32'h100, 32'h0, 32'h1000, 1'b1, 5'd31, lat);
    chk("lat_iters31", 32'(lat), 32'd62);
    repeat (10) @(posedge clk);
    #1;
    chk("stall_out_x", job_if.out_x, 32'h11F);
    chk("stall_in_ready", {31'd0, job_if.in_ready}, 32'd0);
    chk("stall_out_valid", {31'd0, job_if.out_valid}, 32'd1);
    job_if.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_busy", {31'd0, busy}, 32'd0);
    chk("release_in_ready", {31'd0, job_if.in_ready}, 32'd1);

    start_job(32'h55, 32'h66, 32'h77, 1'b0, 5'd10);
    w = 0;
    while (cdc_stage != 5'd5 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk("reach_stage5", {31'd0, (w < 100)}, 32'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_stage", {27'd0, cdc_stage}, 32'd0);
    repeat (30) @(posedge clk);
    #1;
    run_job(32'h1, 32'h2, 32'h3, 1'b0, 5'd2, lat);
    chk("lat_after_abort", 32'(lat), 32'd4);
    @(posedge clk); #1;

    start_job(32'hAA, 32'hBB, 32'hCC, 1'b1, 5'd8);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_out_x", job_if.out_x, 32'd0);
    chk("midrst_stage", {27'd0, cdc_stage}, 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 3000; i++) begin
      job_if.in_valid  = 1'($urandom_range(0, 1));
      job_if.in_x      = $urandom;
      job_if.in_y      = $urandom;
      job_if.in_z      = $urandom;
      job_if.in_mode   = 1'($urandom_range(0, 1));
      job_if.in_iters  = 5'($urandom_range(0, 31));
      job_if.out_ready = ($urandom_range(0, 3) != 0);
      abort            = ($urandom_range(0, 59) == 0);
      @(posedge clk); #1;
    end
    job_if.in_valid  = 1'b0;
    job_if.out_ready = 1'b1;
    abort            = 1'b0;
    repeat (80) @(posedge clk);
    #1;

    flip_en = 1'b1;
    run_job(32'h10, 32'h20, 32'h30, 1'b0, 5'd6, lat);
    chk("lat_flip", 32'(lat), 32'd12);
    chk("flip_mode_err", {31'd0, mode_err}, 32'd1);
    @(posedge clk); #1;
    start_job(32'h1, 32'h1, 32'h1, 1'b1, 5'd5);
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("err_after_abort", {31'd0, mode_err}, 32'd1);
    flip_en = 1'b0;
    run_job(32'h7, 32'h8, 32'h9, 1'b1, 5'd3, lat);
    chk("err_after_job", {31'd0, mode_err}, 32'd1);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
